// File: rtl/l2_noc2_out_arb.sv
// l2_noc2_out_arb
//   Two-pipe to NoC2 output arbiter with single-register output stage.
//   Round-robin among single-flit and header flits; once a header with a
//   non-zero payload length is granted, the same pipe is locked in until
//   its tail flit has been accepted.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   p1_valid/data/ready : pipe1 outbound flit channel
//   p2_valid/data/ready : pipe2 outbound flit channel
//   noc2_valid_out/data_out/ready_out : NoC2 output channel (registered)
//   busy                : high while a multi-flit message holds the lock
//   owner               : current/last granted pipe (0=pipe1, 1=pipe2)
module l2_noc2_out_arb #(
  parameter int LEN_MSB = 29,
  parameter int LEN_LSB = 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p1_valid,
  input  logic [63:0] p1_data,
  output logic        p1_ready,
  input  logic        p2_valid,
  input  logic [63:0] p2_data,
  output logic        p2_ready,
  output logic        noc2_valid_out,
  output logic [63:0] noc2_data_out,
  input  logic        noc2_ready_out,
  output logic        busy,
  output logic        owner
);

  localparam int LEN_W = LEN_MSB - LEN_LSB + 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state_reg;
  logic [LEN_W-1:0]   remaining_reg;
  logic               ptr_reg;        // pipe favoured on a tie in IDLE
  logic               owner_reg;
  logic               busy_reg;
  logic               out_valid_reg;
  logic [63:0]        out_data_reg;

  logic [1:0]         req_valid;
  logic [63:0]        req_data [2];
  logic [1:0]         req_ready;
  logic [1:0]         req_fire;
  logic               grant_sel;
  logic               can_load;
  logic               accept;
  logic [63:0]        acc_data;
  logic [LEN_W-1:0]   hdr_len;

  assign req_valid   = {p2_valid, p1_valid};
  assign req_data[0] = p1_data;
  assign req_data[1] = p2_data;

  // The output register may take a new flit when empty or draining this cycle.
  assign can_load = !out_valid_reg || noc2_ready_out;

  // In LOCK only the owner is eligible. In IDLE a sole requester wins, a tie
  // goes to the pointer; with no requester the pointer side is offered.
  always_comb begin
    grant_sel = ptr_reg;
    if (state_reg == LOCK) begin
      grant_sel = owner_reg;
    end else if (req_valid[0] && !req_valid[1]) begin
      grant_sel = 1'b0;
    end else if (req_valid[1] && !req_valid[0]) begin
      grant_sel = 1'b1;
    end
  end

  // Ready is gated by rst_n so that nothing is offered while reset is held.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pipe
      assign req_ready[gi] = rst_n && can_load && (grant_sel == 1'(gi));
      assign req_fire[gi]  = req_valid[gi] && req_ready[gi];
    end
  endgenerate

  assign accept   = |req_fire;
  assign acc_data = req_data[grant_sel];
  assign hdr_len  = acc_data[LEN_MSB:LEN_LSB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      ptr_reg       <= 1'b0;
      owner_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      // Output stage: load wins over drain, hold while the consumer stalls.
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= acc_data;
      end else if (noc2_ready_out) begin
        out_valid_reg <= 1'b0;
      end

      if (accept) begin
        case (state_reg)
          IDLE: begin
            owner_reg <= grant_sel;
            if (hdr_len == '0) begin
              ptr_reg <= ~grant_sel;
            end else begin
              state_reg     <= LOCK;
              remaining_reg <= hdr_len;
              busy_reg      <= 1'b1;
            end
          end
          LOCK: begin
            if (remaining_reg != '0) begin
              remaining_reg <= remaining_reg - 1'b1;
            end
            // remaining==1 marks the tail flit of the message.
            if (remaining_reg <= LEN_W'(1)) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              ptr_reg   <= ~owner_reg;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign p1_ready       = req_ready[0];
  assign p2_ready       = req_ready[1];
  assign noc2_valid_out = out_valid_reg;
  assign noc2_data_out  = out_data_reg;
  assign busy           = busy_reg;
  assign owner          = owner_reg;

endmodule

// File: tb/tb_l2_noc2_out_arb.sv
module tb_l2_noc2_out_arb;

  logic        clk;
  logic        rst_n;
  logic        p1_valid, p2_valid;
  logic [63:0] p1_data, p2_data;
  logic        p1_ready, p2_ready;
  logic        noc2_valid_out;
  logic [63:0] noc2_data_out;
  logic        noc2_ready_out;
  logic        busy, owner;

  int tests = 0;
  int fails = 0;

  logic [63:0] src1_q[$];
  logic [63:0] src2_q[$];
  logic [63:0] exp_q[$];

  l2_noc2_out_arb #(.LEN_MSB(29), .LEN_LSB(22)) dut (
    .clk(clk), .rst_n(rst_n),
    .p1_valid(p1_valid), .p1_data(p1_data), .p1_ready(p1_ready),
    .p2_valid(p2_valid), .p2_data(p2_data), .p2_ready(p2_ready),
    .noc2_valid_out(noc2_valid_out), .noc2_data_out(noc2_data_out),
    .noc2_ready_out(noc2_ready_out), .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] hdr(input logic [7:0] len, input int id);
    logic [31:0] v;
    v = id;
    return {16'hA5A5, v[15:0], 2'b00, len, v[21:0]};
  endfunction

  function automatic logic [63:0] pl(input int id);
    logic [31:0] v;
    v = id;
    return {16'h5A5A, v[15:0], 2'b11, 8'hFF, v[21:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push1(input logic [63:0] d);
    src1_q.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic push2(input logic [63:0] d);
    src2_q.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && src1_q.size() == 0 && src2_q.size() == 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= max_cyc) begin
      fails++;
      $display("FAIL drain_timeout: %0d flits still expected after %0d cycles", exp_q.size(), n);
    end
  endtask

  // Pipe drivers: present the queue head; pop it after a handshake edge.
  initial begin
    logic acc;
    p1_valid = 1'b0;
    p1_data  = '0;
    forever begin
      @(negedge clk);
      acc = p1_valid && p1_ready;
      @(posedge clk);
      #1;
      if (acc && src1_q.size() > 0) void'(src1_q.pop_front());
      if (src1_q.size() > 0) begin
        p1_valid = 1'b1;
        p1_data  = src1_q[0];
      end else begin
        p1_valid = 1'b0;
      end
    end
  end

  initial begin
    logic acc;
    p2_valid = 1'b0;
    p2_data  = '0;
    forever begin
      @(negedge clk);
      acc = p2_valid && p2_ready;
      @(posedge clk);
      #1;
      if (acc && src2_q.size() > 0) void'(src2_q.pop_front());
      if (src2_q.size() > 0) begin
        p2_valid = 1'b1;
        p2_data  = src2_q[0];
      end else begin
        p2_valid = 1'b0;
      end
    end
  end

  // Monitor: every NoC2 handshake is checked against the scoreboard.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && noc2_valid_out && noc2_ready_out) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL out_unexpected: got %h expected no flit at %0t", noc2_data_out, $time);
        end else begin
          e = exp_q.pop_front();
          if (noc2_data_out !== e) begin
            fails++;
            $display("FAIL out_data: got %h expected %h at %0t", noc2_data_out, e, $time);
          end else begin
            $display("[TB] flit %h ok", noc2_data_out);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int n;
    rst_n          = 1'b0;
    noc2_ready_out = 1'b1;

    // Reset state and single-flit message (L=0, data 0x1).
    push1(64'h1);
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(noc2_valid_out), 64'd0);
    chk("rst_data", noc2_data_out, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_p1_ready", 64'(p1_ready), 64'd0);
    chk("rst_p2_ready", 64'(p2_ready), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("t1_p1_ready", 64'(p1_ready), 64'd1);
    @(negedge clk);
    chk("t1_valid", 64'(noc2_valid_out), 64'd1);
    chk("t1_data", noc2_data_out, 64'h1);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_owner", 64'(owner), 64'd0);
    wait_drain(20);

    // Contention: pipe1 was served last, so pipe2 goes first, then alternate.
    for (int i = 0; i < 4; i++) begin
      src2_q.push_back(hdr(8'd0, 200 + i));
      src1_q.push_back(hdr(8'd0, 100 + i));
      exp_q.push_back(hdr(8'd0, 200 + i));
      exp_q.push_back(hdr(8'd0, 100 + i));
    end
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_valid", 64'(noc2_valid_out), 64'd1);
      chk("t2_owner", 64'(owner), (i % 2 == 0) ? 64'd1 : 64'd0);
    end
    wait_drain(30);

    // Lock: pipe2 L=3 message while pipe1 keeps a header pending.
    push2(hdr(8'd3, 300));
    push2(pl(301));
    push2(pl(302));
    push2(pl(303));
    push1(hdr(8'd0, 310));
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) chk("t3_p2_ready", 64'(p2_ready), 64'd1);
      chk("t3_p1_ready", 64'(p1_ready), (i == 4) ? 64'd1 : 64'd0);
      chk("t3_busy", 64'(busy), (i >= 1 && i <= 3) ? 64'd1 : 64'd0);
    end
    wait_drain(30);

    // Backpressure: stall 5 cycles after header and first payload.
    push1(hdr(8'd3, 400));
    push1(pl(401));
    push1(pl(402));
    push1(pl(403));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    noc2_ready_out = 1'b0;
    push2(hdr(8'd0, 410));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_data", noc2_data_out, pl(401));
      chk("t4_hold_valid", 64'(noc2_valid_out), 64'd1);
      chk("t4_p1_ready", 64'(p1_ready), 64'd0);
      chk("t4_p2_ready", 64'(p2_ready), 64'd0);
      chk("t4_busy", 64'(busy), 64'd1);
    end
    @(posedge clk);
    #1 noc2_ready_out = 1'b1;
    wait_drain(30);

    // Boundary: L=255 locks for exactly 255 payloads; pipe2 waits, then wins.
    push1(hdr(8'd255, 500));
    for (int i = 0; i < 255; i++) push1(pl(1000 + i));
    push1(hdr(8'd0, 501));
    src2_q.push_back(hdr(8'd0, 510));
    void'(exp_q.pop_back());
    exp_q.push_back(hdr(8'd0, 510));
    exp_q.push_back(hdr(8'd0, 501));
    busy_cnt = 0;
    n = 0;
    while (!(exp_q.size() == 0 && src1_q.size() == 0 && src2_q.size() == 0) && n < 2000) begin
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
    end
    chk("t5_drained", 64'(n < 2000), 64'd1);
    chk("t5_busy_cycles", 64'(busy_cnt), 64'd255);
    @(negedge clk);
    chk("t5_busy_end", 64'(busy), 64'd0);

    // Reset mid-message: pipe2 L=4, reset after header + 2 payloads.
    push2(hdr(8'd4, 600));
    for (int i = 0; i < 4; i++) push2(pl(601 + i));
    n = 0;
    while (src2_q.size() > 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached", 64'(n < 50), 64'd1);
    chk("t6_busy_pre", 64'(busy), 64'd1);
    chk("t6_owner_pre", 64'(owner), 64'd1);
    #1 rst_n = 1'b0;
    src1_q.delete();
    src2_q.delete();
    exp_q.delete();
    #1;
    chk("t6_rst_valid", 64'(noc2_valid_out), 64'd0);
    chk("t6_rst_data", noc2_data_out, 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_owner", 64'(owner), 64'd0);
    chk("t6_rst_p1_ready", 64'(p1_ready), 64'd0);
    chk("t6_rst_p2_ready", 64'(p2_ready), 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    // Fresh header L=1 on pipe1 wins the tie (pointer back on pipe1).
    push1(hdr(8'd1, 700));
    push1(pl(701));
    push2(hdr(8'd0, 710));
    wait_drain(30);
    @(negedge clk);
    chk("t6_busy_end", 64'(busy), 64'd0);
    chk("t6_owner_end", 64'(owner), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
